grf_wb_arbiter: RTL
===================

# grf_wb_arbiter

Write-port arbiter and pending-write scoreboard for the 32x32 general register file. The register file has one write port. Two sources share it: the in-order pipeline writeback stage, and the multi-cycle multiply/divide unit (MDU) returning results out of band. MDU results are buffered in a small FIFO, and issued-but-unreturned MDU destinations are tracked so decode can stall on RAW and WAW hazards. The block sits between the W stage, the MDU and the register file write port (A3/WD/RegWr/pc8).

## Interface
- DEPTH, 2 — MDU result FIFO entries (power of two, ≥2)
- STARVE_LIM, 4 — consecutive cycles a non-empty FIFO may lose arbitration before the W stage is held
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- wb_we  in  1  W-stage write request
- wb_addr  in  5  W-stage destination
- wb_data  in  32  W-stage write data
- wb_pc8  in  32  W-stage PC+8, forwarded for trace
- md_valid  in  1  MDU result valid
- md_addr  in  5  MDU result destination
- md_data  in  32  MDU result data
- md_pc8  in  32  PC+8 of the MDU-issuing instruction
- md_ready  out  1  FIFO can accept (not full, reset deasserted)
- iss_valid  in  1  MDU instruction with register destination issued this cycle
- iss_addr  in  5  its destination
- rd_a1, rd_a2, rd_a3  in  5 each  decode-stage source 1, source 2 and destination
- hazard_stall  out  1  decode must stall
- wb_hold  out  1  W stage must hold and re-present the same request next cycle
- grf_we, grf_a3, grf_wd, grf_pc8  out  1/5/32/32  to register file RegWr/A3/WD/pc8
- busy_vec  out  32  scoreboard, bit n = register n has an outstanding MDU write

## Operation
- FIFO: push when md_valid && md_ready. Entry = {addr, data, pc8}. No same-cycle bypass to the write port. Writes with md_addr==0 are pushed, then dropped at pop with no grf_we.
- Arbitration, evaluated each cycle:
  - hold = (starve_cnt == STARVE_LIM) && FIFO non-empty.
  - If hold: grant FIFO head and drive wb_hold=1. The W request is ignored this cycle.
  - Else if wb_we && wb_addr!=0: grant W.
  - Else if FIFO non-empty: grant FIFO head (pop).
  - Else grf_we=0.
- grf_* outputs are combinational from the granted source. grf_we=0 for an addr-0 pop.
- starve_cnt: 0..STARVE_LIM.
  - Increments when FIFO is non-empty and not granted.
  - Clears on any FIFO grant or when FIFO is empty.
  - Saturates.
- Scoreboard:
  - iss_valid && iss_addr!=0 sets busy[iss_addr].
  - A FIFO pop of addr n clears busy[n].
  - Set and clear of the same bit in one cycle: set wins.
  - iss_valid to an already-busy register is a protocol violation. Decode prevents it via rd_a3.
- hazard_stall = OR over x in {rd_a1, rd_a2, rd_a3} of (x!=0 && busy[x]). Combinational.
- Push and pop in the same cycle on a full FIFO is not allowed: md_ready is low when full, regardless of pop.

## Timing
- Reset (reset low, asynchronous): FIFO empty, busy_vec=0, starve_cnt=0, md_ready=0, wb_hold=0, hazard_stall=0, grf_we=0.
- md_ready rises combinationally once reset is high.
- MDU result to register file: minimum 1 cycle. Pushed at edge k, written at edge k+1 if no W request.
- busy bit:
  - Visible one cycle after iss_valid (hazard_stall uses the registered busy_vec).
  - Clears at the edge of the pop write. Decode sees the new value through the register file's internal write bypass the same cycle the stall drops.
- A W request that loses to hold is not written. The W stage must keep wb_we/addr/data stable for one more cycle.
- FIFO pointers wrap modulo DEPTH. Full = DEPTH entries. Occupancy counter is log2(DEPTH)+1 bits.
- Reset asserted mid-operation discards FIFO contents and the scoreboard. The core is restarted by the same reset.

## Test plan
- Reset state: reset low → busy_vec=0, md_ready=0, grf_we=0. Release → md_ready=1 next sample.
- Lone MDU result: iss_valid addr 8; 3 cycles later md_valid addr 8 data 0x1234 → hazard_stall for rd_a1=8 from cycle+1 until pop. grf_we with A3=8, WD=0x1234 one cycle after push. busy[8] cleared.
- Contention: wb_we addr 3 every cycle while MDU pushes addr 5 → W granted for STARVE_LIM=4 cycles, then wb_hold=1 and FIFO head written. The held W request is written the next cycle.
- Full FIFO: DEPTH pushes with W busy → md_ready=0 after the 2nd push. Resumes high the cycle after the first pop. No data loss; order preserved.
- Addr 0: iss_valid addr 0 and md_valid addr 0 → busy_vec unchanged. Entry popped with grf_we=0.
- Async reset mid-operation: 2 FIFO entries plus busy bits, pull reset low between edges → FIFO empty and busy_vec=0 immediately, no grf_we afterwards.

Source files
------------

// File: rtl/grf_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// grf_wb_arbiter_if
// Bundles every signal between the register-file write-port arbiter and its
// neighbours: the W stage, the MDU result path, MDU issue, decode and the
// register file write port.
//   slave  : view used by the arbiter (requests in, grants/status out)
//   master : view used by the surrounding core or a testbench
// ----------------------------------------------------------------------------
interface grf_wb_arbiter_if;
    // W-stage write request
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] wb_pc8;
    logic        wb_hold;
    // MDU result path
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic [31:0] md_pc8;
    logic        md_ready;
    // MDU issue and decode hazard query
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic [4:0]  rd_a1;
    logic [4:0]  rd_a2;
    logic [4:0]  rd_a3;
    logic        hazard_stall;
    logic [31:0] busy_vec;
    // Register file write port
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc8;

    modport slave (
        input  wb_we, wb_addr, wb_data, wb_pc8,
        input  md_valid, md_addr, md_data, md_pc8,
        input  iss_valid, iss_addr, rd_a1, rd_a2, rd_a3,
        output wb_hold, md_ready, hazard_stall, busy_vec,
        output grf_we, grf_a3, grf_wd, grf_pc8
    );

    modport master (
        output wb_we, wb_addr, wb_data, wb_pc8,
        output md_valid, md_addr, md_data, md_pc8,
        output iss_valid, iss_addr, rd_a1, rd_a2, rd_a3,
        input  wb_hold, md_ready, hazard_stall, busy_vec,
        input  grf_we, grf_a3, grf_wd, grf_pc8
    );
endinterface

// File: rtl/grf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// grf_wb_arbiter
// Shares the single register-file write port between the in-order W stage and
// out-of-band MDU results. MDU results are queued in a small FIFO; a starvation
// counter forces a FIFO write (holding the W stage) after STARVE_LIM lost
// arbitrations. A scoreboard tracks MDU destinations that have issued but not
// yet been written so decode can stall on RAW/WAW hazards.
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous active-low reset
//   bus    grf_wb_arbiter_if.slave: W request/hold, MDU result/ready, MDU
//          issue, decode sources/destination, hazard_stall, busy_vec and the
//          register file write port (grf_we/grf_a3/grf_wd/grf_pc8)
// ----------------------------------------------------------------------------
module grf_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic            clk,
    input  logic            reset,
    grf_wb_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [SW-1:0] LIM      = SW'(STARVE_LIM);

    // FIFO storage carries data only; it is never reset.
    logic [4:0]    fifo_addr [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_pc8  [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [SW-1:0] starve_cnt;
    logic [31:0]   busy_q, busy_nxt;

    logic          empty, push, pop, hold, grant_w;
    logic [4:0]    head_addr;

    assign empty     = (count == '0);
    assign head_addr = fifo_addr[rd_ptr];

    // md_ready is low while reset is asserted and whenever full, even if a
    // pop happens in the same cycle.
    assign bus.md_ready = reset && (count != FULL_CNT);
    assign push         = bus.md_valid && bus.md_ready;

    // Arbitration: forced FIFO grant when starved, else W, else FIFO head.
    assign hold    = (starve_cnt == LIM) && !empty;
    assign grant_w = reset && !hold && bus.wb_we && (bus.wb_addr != 5'd0);
    assign pop     = !empty && !grant_w;

    assign bus.wb_hold = hold;

    always_comb begin
        bus.grf_we  = 1'b0;
        bus.grf_a3  = 5'd0;
        bus.grf_wd  = 32'd0;
        bus.grf_pc8 = 32'd0;
        if (grant_w) begin
            bus.grf_we  = 1'b1;
            bus.grf_a3  = bus.wb_addr;
            bus.grf_wd  = bus.wb_data;
            bus.grf_pc8 = bus.wb_pc8;
        end else if (pop) begin
            // Entries destined for $0 are drained without a write.
            bus.grf_we  = (head_addr != 5'd0);
            bus.grf_a3  = head_addr;
            bus.grf_wd  = fifo_data[rd_ptr];
            bus.grf_pc8 = fifo_pc8[rd_ptr];
        end
    end

    // Scoreboard next state: clear on pop, then set on issue so that a
    // same-cycle set and clear of one bit leaves it set.
    always_comb begin
        busy_nxt = busy_q;
        if (pop && head_addr != 5'd0) begin
            busy_nxt[head_addr] = 1'b0;
        end
        if (bus.iss_valid && bus.iss_addr != 5'd0) begin
            busy_nxt[bus.iss_addr] = 1'b1;
        end
    end

    assign bus.busy_vec     = busy_q;
    assign bus.hazard_stall = ((bus.rd_a1 != 5'd0) && busy_q[bus.rd_a1]) ||
                              ((bus.rd_a2 != 5'd0) && busy_q[bus.rd_a2]) ||
                              ((bus.rd_a3 != 5'd0) && busy_q[bus.rd_a3]);

    // ---- control state: pointers, occupancy, starvation, scoreboard ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            busy_q     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (empty || pop) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            busy_q <= busy_nxt;
        end
    end

    // ---- FIFO data write ----
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.md_addr;
            fifo_data[wr_ptr] <= bus.md_data;
            fifo_pc8[wr_ptr]  <= bus.md_pc8;
        end
    end
endmodule
